// File: rtl/greenrisc_pkg.sv
// Shared types and constants for the greenrisc instruction-memory loader.
// Imported by the loader top, its word buffer and its bus interface.
package greenrisc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/imem_flash_loader_if.sv
// Programming-byte input and imem word-write bus of the flash loader.
// master drives bytes and receives writes; slave is the loader.
interface imem_flash_loader_if #(
  parameter int ADDR_W = 14
);

  logic              flash;
  logic [7:0]        data;
  logic [ADDR_W-1:0] addr;
  logic              imem_we;
  logic [ADDR_W-3:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [3:0]        imem_wstrb;

  modport master (
    output flash, data, addr,
    input  imem_we, imem_waddr,
    input  imem_wdata, imem_wstrb
  );

  modport slave (
    input  flash, data, addr,
    output imem_we, imem_waddr,
    output imem_wdata, imem_wstrb
  );

endinterface

// File: rtl/imem_wordbuf.sv
// Byte-lane merge register: one partial 32-bit word, its lane mask and
// word address. o_mdata/o_full preview the word with the incoming byte.
module imem_wordbuf
  import greenrisc_pkg::*;
#(
  parameter int WA_W = 12
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_load,
  input  logic                      i_merge,
  input  logic                      i_clear,
  input  logic [LANE_W-1:0]         i_lane,
  input  logic [7:0]                i_byte,
  input  logic [WA_W-1:0]           i_waddr,
  output logic [31:0]               o_data,
  output logic [BYTES_PER_WORD-1:0] o_mask,
  output logic [WA_W-1:0]           o_waddr,
  output logic [31:0]               o_mdata,
  output logic                      o_full
);

  logic [31:0]               r_data;
  logic [BYTES_PER_WORD-1:0] r_mask;
  logic [WA_W-1:0]           r_waddr;
  logic [31:0]               w_ldata;
  logic [BYTES_PER_WORD-1:0] w_lmask;
  logic [31:0]               w_mdata;
  logic [BYTES_PER_WORD-1:0] w_mmask;

  always_comb begin
    w_ldata = '0;
    w_lmask = '0;
    w_mdata = r_data;
    w_mmask = r_mask;
    w_ldata[8*i_lane +: 8] = i_byte;
    w_lmask[i_lane] = 1'b1;
    w_mdata[8*i_lane +: 8] = i_byte;
    w_mmask[i_lane] = 1'b1;
  end

  // clear beats load beats merge: a completed word empties the buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data  <= '0;
      r_mask  <= '0;
      r_waddr <= '0;
    end else if (i_clear) begin
      r_data  <= '0;
      r_mask  <= '0;
    end else if (i_load) begin
      r_data  <= w_ldata;
      r_mask  <= w_lmask;
      r_waddr <= i_waddr;
    end else if (i_merge) begin
      r_data  <= w_mdata;
      r_mask  <= w_mmask;
      r_waddr <= i_waddr;
    end
  end

  assign o_data  = r_data;
  assign o_mask  = r_mask;
  assign o_waddr = r_waddr;
  assign o_mdata = w_mdata;
  assign o_full  = &w_mmask;

endmodule

// File: rtl/imem_flash_loader.sv
// Packs flash programming bytes into imem word writes and holds the core.
// Define LOADER_CKSUM_EN to build the running 16-bit byte checksum.
module imem_flash_loader
  import greenrisc_pkg::*;
#(
  parameter int ADDR_W      = 14,
  parameter int TIMEOUT     = 16,
  parameter int HOLD_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  imem_flash_loader_if.slave   bus,
  output logic                 core_hold,
  output logic                 busy,
  output logic [15:0]          cksum
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int CMAX  = (TIMEOUT > HOLD_CYCLES) ? TIMEOUT : HOLD_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);

  loader_state_t             r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      r_we;
  logic [WA_W-1:0]           r_waddr;
  logic [31:0]               r_wdata;
  logic [3:0]                r_wstrb;
  logic                      r_hold;
  logic                      r_busy;

  logic [WA_W-1:0]           w_wa;
  logic [LANE_W-1:0]         w_lane;
  logic [31:0]               w_bdata;
  logic [BYTES_PER_WORD-1:0] w_bmask;
  logic [WA_W-1:0]           w_bwa;
  logic [31:0]               w_mdata;
  logic                      w_full;
  logic                      w_evict;
  logic                      w_load;
  logic                      w_merge;
  logic                      w_clear;
  logic                      w_tmo;
  logic                      w_hend;

  assign w_wa    = bus.addr[ADDR_W-1:2];
  assign w_lane  = bus.addr[LANE_W-1:0];
  assign w_tmo   = (r_cnt == CNT_W'(TIMEOUT - 1));
  assign w_hend  = (r_cnt == CNT_W'(HOLD_CYCLES - 1));
  assign w_evict = bus.flash && (r_state == ACCUM)
                && (|w_bmask) && (w_bwa != w_wa);
  assign w_load  = bus.flash && ((r_state != ACCUM) || w_evict);
  assign w_merge = bus.flash && (r_state == ACCUM) && !w_evict;
  assign w_clear = (w_merge && w_full)
                || ((r_state == ACCUM) && !bus.flash && w_tmo);

  imem_wordbuf #(
    .WA_W (WA_W)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .i_load  (w_load),
    .i_merge (w_merge),
    .i_clear (w_clear),
    .i_lane  (w_lane),
    .i_byte  (bus.data),
    .i_waddr (w_wa),
    .o_data  (w_bdata),
    .o_mask  (w_bmask),
    .o_waddr (w_bwa),
    .o_mdata (w_mdata),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_hold  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.flash) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
            r_hold  <= 1'b1;
            r_busy  <= 1'b1;
          end
        end
        ACCUM: begin
          // an arriving byte always beats the idle timeout
          if (bus.flash) begin
            r_cnt <= '0;
            if (w_evict) begin
              r_we    <= 1'b1;
              r_waddr <= w_bwa;
              r_wdata <= w_bdata;
              r_wstrb <= w_bmask;
            end else if (w_full) begin
              r_we    <= 1'b1;
              r_waddr <= w_wa;
              r_wdata <= w_mdata;
              r_wstrb <= 4'hF;
            end
          end else if (w_tmo) begin
            if (|w_bmask) begin
              r_we    <= 1'b1;
              r_waddr <= w_bwa;
              r_wdata <= w_bdata;
              r_wstrb <= w_bmask;
            end
            r_state <= DRAIN;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.flash) begin
            r_state <= ACCUM;
            r_cnt   <= '0;
          end else if (w_hend) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_hold  <= 1'b0;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CKSUM_EN
  logic [15:0] r_cksum;

  // a fresh session restarts the sum at its first byte
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cksum <= '0;
    end else if (bus.flash) begin
      if (r_state == IDLE) r_cksum <= {8'h00, bus.data};
      else r_cksum <= r_cksum + {8'h00, bus.data};
    end
  end

  assign cksum = r_cksum;
`else
  assign cksum = 16'h0000;
`endif

  assign bus.imem_we    = r_we;
  assign bus.imem_waddr = r_waddr;
  assign bus.imem_wdata = r_wdata;
  assign bus.imem_wstrb = r_wstrb;
  assign core_hold      = r_hold;
  assign busy           = r_busy;

endmodule

// File: tb/tb_imem_flash_loader.sv
// Directed bench for imem_flash_loader; expected values are hand-derived.
// Honours LOADER_CKSUM_EN for the checksum expectations.
module tb_imem_flash_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_hold;
  logic        busy;
  logic [15:0] cksum;
  logic        seen;
  int          total = 0;
  int          bad = 0;

  imem_flash_loader_if bus ();

  imem_flash_loader dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .core_hold (core_hold),
    .busy      (busy),
    .cksum     (cksum)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] b, input logic [13:0] a);
    bus.flash = 1'b1;
    bus.data  = b;
    bus.addr  = a;
    tick();
    bus.flash = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.flash = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_wr(input string tag, input logic [11:0] wa,
                        input logic [31:0] wd, input logic [3:0] ws);
    chk({tag, ".we"}, 32'(bus.imem_we), 32'd1);
    chk({tag, ".waddr"}, 32'(bus.imem_waddr), 32'(wa));
    chk({tag, ".wdata"}, bus.imem_wdata, wd);
    chk({tag, ".wstrb"}, 32'(bus.imem_wstrb), 32'(ws));
  endtask

  initial begin
    bus.flash = 1'b0;
    bus.data  = 8'h00;
    bus.addr  = '0;
    idle(2);
    chk("rst.we", 32'(bus.imem_we), 32'd0);
    chk("rst.wdata", bus.imem_wdata, 32'd0);
    chk("rst.hold", 32'(core_hold), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cksum", 32'(cksum), 32'd0);
    reset = 1'b1;
    idle(1);

    // sequential word
    put(8'h13, 14'd0);
    chk("seq.hold", 32'(core_hold), 32'd1);
    chk("seq.busy", 32'(busy), 32'd1);
    chk("seq.we0", 32'(bus.imem_we), 32'd0);
    put(8'h05, 14'd1);
    put(8'h10, 14'd2);
    chk("seq.we2", 32'(bus.imem_we), 32'd0);
    put(8'h00, 14'd3);
    chk_wr("seq", 12'd0, 32'h0010_0513, 4'hF);
    idle(1);
    chk("seq.pulse", 32'(bus.imem_we), 32'd0);

    // eviction, then timeout flush of the new buffer and drain
    put(8'hA1, 14'd4);
    chk("ev.we4", 32'(bus.imem_we), 32'd0);
    put(8'hB2, 14'd5);
    put(8'hC3, 14'd8);
    chk_wr("ev", 12'd1, 32'h0000_B2A1, 4'b0011);
    idle(15);
    chk("tmo.early", 32'(bus.imem_we), 32'd0);
    idle(1);
    chk_wr("tmo", 12'd2, 32'h0000_00C3, 4'b0001);
    idle(3);
    chk("drain.hold", 32'(core_hold), 32'd1);
    chk("drain.busy", 32'(busy), 32'd1);
    idle(1);
    chk("rel.hold", 32'(core_hold), 32'd0);
    chk("rel.busy", 32'(busy), 32'd0);

    // single byte flushed by timeout, then re-entry from DRAIN
    put(8'hAB, 14'd14);
    idle(15);
    chk("ab.early", 32'(bus.imem_we), 32'd0);
    idle(1);
    chk_wr("ab", 12'd3, 32'h00AB_0000, 4'b0100);
    idle(1);
    put(8'h01, 14'h20);
    idle(3);
    chk("rd.hold", 32'(core_hold), 32'd1);
    put(8'h02, 14'h21);
    put(8'h03, 14'h22);
    put(8'h04, 14'h23);
    chk_wr("rd", 12'd8, 32'h0403_0201, 4'hF);
    idle(20);
    chk("rd.idle", 32'(busy), 32'd0);

    // flash coinciding with timeout expiry keeps accumulating
    put(8'h5A, 14'h40);
    idle(15);
    put(8'h6B, 14'h41);
    chk("sim.we", 32'(bus.imem_we), 32'd0);
    chk("sim.busy", 32'(busy), 32'd1);
    idle(15);
    chk("sim.early", 32'(bus.imem_we), 32'd0);
    idle(1);
    chk_wr("sim", 12'h10, 32'h0000_6B5A, 4'b0011);
    idle(4);
    chk("sim.hold", 32'(core_hold), 32'd0);

    // lane overwrite, last write wins
    put(8'h11, 14'h0);
    put(8'h22, 14'h0);
    chk("ow.we0", 32'(bus.imem_we), 32'd0);
    put(8'h33, 14'h1);
    put(8'h44, 14'h2);
    chk("ow.we2", 32'(bus.imem_we), 32'd0);
    put(8'h55, 14'h3);
    chk_wr("ow", 12'd0, 32'h5544_3322, 4'hF);
    idle(20);

    // checksum
    put(8'hFF, 14'h100);
`ifdef LOADER_CKSUM_EN
    chk("ck.first", 32'(cksum), 32'h00FF);
`else
    chk("ck.first", 32'(cksum), 32'h0000);
`endif
    put(8'hFF, 14'h101);
    put(8'h02, 14'h102);
`ifdef LOADER_CKSUM_EN
    chk("ck.sum", 32'(cksum), 32'h0200);
`else
    chk("ck.sum", 32'(cksum), 32'h0000);
`endif

    // asynchronous reset with a partial word in flight
    reset = 1'b0;
    #2;
    chk("ar.hold", 32'(core_hold), 32'd0);
    chk("ar.busy", 32'(busy), 32'd0);
    chk("ar.waddr", 32'(bus.imem_waddr), 32'd0);
    chk("ar.wdata", bus.imem_wdata, 32'd0);
    chk("ar.wstrb", 32'(bus.imem_wstrb), 32'd0);
    chk("ar.cksum", 32'(cksum), 32'd0);
    idle(2);
    reset = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      seen = seen | bus.imem_we;
    end
    chk("ar.nowrite", 32'(seen), 32'd0);
    chk("ar.idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_flash_loader.md
Name: imem_flash_loader

Overview:
- Upstream feeder of the instruction memory.
- Accepts byte-wide programming writes (flash strobe, data, byte addr) and packs them into little-endian 32-bit words.
- Issues single-cycle word writes with byte strobes to imem.
- Holds the core (pc) in reset while programming is in progress, then releases it after a quiet period.

Parameters:
- ADDR_W, 14: byte address width; word address is ADDR_W-2 bits.
- TIMEOUT, 16: idle cycles without flash in ACCUM before a partial word is flushed.
- HOLD_CYCLES, 4: cycles core_hold stays high after the final write, before release.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- flash  in  1  byte write strobe; one byte accepted per cycle while high
- data  in  8  programming byte
- addr  in  ADDR_W  byte address; [1:0] selects lane, [ADDR_W-1:2] selects word
- imem_we  out  1  one-cycle imem write pulse
- imem_waddr  out  ADDR_W-2  word address
- imem_wdata  out  32  packed word (lane n = bits 8n+7:8n)
- imem_wstrb  out  4  valid-lane mask for the write
- core_hold  out  1  high = pc/core held in reset
- busy  out  1  high in any state other than IDLE
- cksum  out  16  running byte sum (see Optional Feature)

Behaviour:
- Reset (reset low, async): state=IDLE; imem_we=0; imem_waddr=0; imem_wdata=0; imem_wstrb=0; core_hold=0; busy=0; cksum=0. Buffer and mask are cleared. A partial word in flight is discarded and no write is issued.
- All outputs are registered. At most one imem_we per cycle.
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE:
  - On flash: load byte into lane addr[1:0], word_addr=addr[ADDR_W-1:2], mask=1<<lane.
  - Go to ACCUM; core_hold=1 from the next edge.
- ACCUM:
  - flash, same word: merge byte. A repeated lane overwrites (last write wins).
  - Merge completes mask=4'hF: imem_we=1 next cycle with wstrb=4'hF. Clear buffer and mask.
  - flash, different word: next cycle write the old buffer (partial wstrb allowed). The new byte starts a fresh buffer in the same edge, so no byte is dropped.
  - Idle counter resets on every flash. When it reaches TIMEOUT: flush the partial buffer if mask≠0 (otherwise no write), then go to DRAIN.
- DRAIN:
  - Counts HOLD_CYCLES, then goes to IDLE with core_hold=0.
  - flash during DRAIN: return to ACCUM with that byte as a fresh buffer. Counter clears; core_hold stays 1.
- Latency: byte that completes or evicts a word → imem_we exactly 1 cycle later.
- Address wrap: word address is not incremented internally; caller-supplied addresses are used as-is.
- Simultaneous flash and timeout expiry: flash wins and the counter clears.

Optional Feature:
- Macro: LOADER_CKSUM_EN.
- Defined: cksum accumulates the 16-bit wrap-around sum of every accepted byte. It is cleared on the IDLE→ACCUM transition and holds its value in DRAIN and IDLE.
- Undefined: cksum is tied to 16'h0 and no adder is generated.

Decomposition:
- Shared package greenrisc_pkg holds:
  - loader_state_t enum (IDLE, ACCUM, DRAIN).
  - BYTES_PER_WORD=4.
  - Lane-index width constant.
- Sub-module imem_wordbuf: byte-lane merge register holding data[31:0], mask[3:0] and word_addr, with load/merge/clear controls and a full flag. The FSM stays in imem_flash_loader.

Test Plan:
- Sequential word: bytes 0x13,0x05,0x10,0x00 to addr 0..3 on consecutive cycles → one imem_we, waddr=0, wdata=0x00100513, wstrb=4'hF, one cycle after the 4th byte; core_hold high from cycle 1.
- Eviction: bytes at addr 4,5 then addr 8 → write waddr=1, wstrb=4'b0011; then a new buffer at word 2, lane 0.
- Timeout flush: single byte 0xAB at addr 14, then idle → after 16 cycles write waddr=3, wdata[23:16]=0xAB, wstrb=4'b0100; core_hold drops 4 cycles later.
- Overwrite: addr 0 gets 0x11 then 0x22, then lanes 1-3 → wdata[7:0]=0x22, single write.
- Async reset mid-word: reset low after 2 bytes → all outputs 0 immediately, no imem_we after release.
- LOADER_CKSUM_EN: bytes 0xFF,0xFF,0x02 → cksum=16'h0200; without the macro, cksum=0.
